// File: rtl/butterfly_result_serializer.sv
// butterfly_result_serializer
// Captures the four butterfly result words on the butterfly done pulse and
// streams them one byte at a time into a UART transmitter using a start/done
// handshake. Each word goes out LSB first, in the order out0_re, out0_im,
// out1_re, out1_im.
//
// Build option: define SERIALIZER_HEADER_EN to prefix every frame with
// HEADER_BYTE. Without it, a frame is exactly BYTE_COUNT data bytes.
//
// state       | meaning
// ------------+--------------------------------------------------------
// S_IDLE      | no frame in flight, waiting for i_valid
// S_START     | o_tx_start high for one cycle, o_tx_byte presented
// S_WAIT_DONE | waiting (unbounded) for the UART's i_tx_done
// S_FINISH    | o_frame_done pulse; a new i_valid here is accepted

module butterfly_result_serializer #(
  parameter int         WORD_SIZE   = 16,
  parameter logic [7:0] HEADER_BYTE = 8'hA5
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_valid,
  input  logic [WORD_SIZE-1:0] i_out0_re,
  input  logic [WORD_SIZE-1:0] i_out0_im,
  input  logic [WORD_SIZE-1:0] i_out1_re,
  input  logic [WORD_SIZE-1:0] i_out1_im,
  input  logic                 i_tx_done,
  output logic                 o_tx_start,
  output logic [7:0]           o_tx_byte,
  output logic                 o_busy,
  output logic                 o_frame_done,
  output logic                 o_overrun
);

  localparam int BYTE_COUNT = 4 * WORD_SIZE / 8;
`ifdef SERIALIZER_HEADER_EN
  localparam int HDR_LEN = 1;
`else
  localparam int HDR_LEN = 0;
`endif
  localparam int FRAME_LEN = BYTE_COUNT + HDR_LEN;
  localparam int IDX_W     = $clog2(FRAME_LEN);
  localparam int CAP_W     = 4 * WORD_SIZE;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_WAIT_DONE,
    S_FINISH
  } state_t;

  state_t           state_q;
  logic [CAP_W-1:0] cap_q;
  logic [CAP_W-1:0] cap_d;
  logic [IDX_W-1:0] idx_q;
  logic [IDX_W-1:0] idx_d;
  logic [7:0]       tx_byte_q;
  logic [7:0]       byte_d;
  logic             tx_start_q;
  logic             busy_q;
  logic             frame_done_q;
  logic             overrun_q;
  logic             accept;

  // Frame position idx maps to the header (if enabled) or a captured data byte.
  // A constant-index mux keeps every select in range for any WORD_SIZE.
  function automatic logic [7:0] frame_byte(input logic [CAP_W-1:0] frame,
                                            input logic [IDX_W-1:0] idx);
    logic [7:0] b;
    b = 8'h00;
    if (HDR_LEN == 1 && idx == '0) begin
      b = HEADER_BYTE;
    end else begin
      for (int n = 0; n < BYTE_COUNT; n++) begin
        if (idx == IDX_W'(n + HDR_LEN)) b = frame[8*n +: 8];
      end
    end
    return b;
  endfunction

  // A new frame is only taken when nothing is in flight (IDLE or FINISH).
  assign accept = i_valid && (state_q == S_IDLE || state_q == S_FINISH);

  // Work out which frame/index the next START will present, so the byte can be
  // registered on the same edge that raises o_tx_start.
  always_comb begin
    cap_d  = accept ? {i_out1_im, i_out1_re, i_out0_im, i_out0_re} : cap_q;
    idx_d  = accept ? '0 : idx_q + IDX_W'(1);
    byte_d = frame_byte(cap_d, idx_d);
  end

  // Serializer FSM with all outputs registered.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q      <= S_IDLE;
      cap_q        <= '0;
      idx_q        <= '0;
      tx_byte_q    <= 8'h00;
      tx_start_q   <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      tx_start_q   <= 1'b0;
      frame_done_q <= 1'b0;
      case (state_q)
        S_IDLE, S_FINISH: begin
          if (accept) begin
            cap_q      <= cap_d;
            idx_q      <= idx_d;
            tx_byte_q  <= byte_d;
            tx_start_q <= 1'b1;
            busy_q     <= 1'b1;
            state_q    <= S_START;
          end else begin
            state_q    <= S_IDLE;
          end
        end
        S_START: begin
          // A done pulse here cannot belong to the byte just started; drop it.
          if (i_valid) overrun_q <= 1'b1;
          state_q <= S_WAIT_DONE;
        end
        S_WAIT_DONE: begin
          if (i_valid) overrun_q <= 1'b1;
          if (i_tx_done) begin
            if (idx_q == LAST_IDX) begin
              frame_done_q <= 1'b1;
              busy_q       <= 1'b0;
              state_q      <= S_FINISH;
            end else begin
              idx_q      <= idx_d;
              tx_byte_q  <= byte_d;
              tx_start_q <= 1'b1;
              state_q    <= S_START;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign o_tx_start   = tx_start_q;
  assign o_tx_byte    = tx_byte_q;
  assign o_busy       = busy_q;
  assign o_frame_done = frame_done_q;
  assign o_overrun    = overrun_q;

endmodule

// File: tb/tb_butterfly_result_serializer.sv
// Testbench for butterfly_result_serializer: a UART model answers each start
// pulse with a done pulse after a programmable delay, and a byte queue holds
// the bytes expected on the wire.

module tb_butterfly_result_serializer;

  localparam int WORD_SIZE = 16;
`ifdef SERIALIZER_HEADER_EN
  localparam int FRAME_LEN = 9;
`else
  localparam int FRAME_LEN = 8;
`endif

  logic                 clk;
  logic                 rst;
  logic                 i_valid;
  logic [WORD_SIZE-1:0] i_out0_re, i_out0_im, i_out1_re, i_out1_im;
  logic                 i_tx_done;
  logic                 o_tx_start;
  logic [7:0]           o_tx_byte;
  logic                 o_busy;
  logic                 o_frame_done;
  logic                 o_overrun;

  int         n_checks = 0;
  int         n_fail   = 0;
  logic [7:0] exp_q[$];

  butterfly_result_serializer #(.WORD_SIZE(WORD_SIZE)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_valid      (i_valid),
    .i_out0_re    (i_out0_re),
    .i_out0_im    (i_out0_im),
    .i_out1_re    (i_out1_re),
    .i_out1_im    (i_out1_im),
    .i_tx_done    (i_tx_done),
    .o_tx_start   (o_tx_start),
    .o_tx_byte    (o_tx_byte),
    .o_busy       (o_busy),
    .o_frame_done (o_frame_done),
    .o_overrun    (o_overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic push_word(input logic [15:0] w);
    exp_q.push_back(w[7:0]);
    exp_q.push_back(w[15:8]);
  endtask

  // Drive a valid pulse for the current cycle; the caller ticks and clears it.
  task automatic send(input logic [15:0] r0, input logic [15:0] m0,
                      input logic [15:0] r1, input logic [15:0] m1, input bit accept);
    i_out0_re = r0; i_out0_im = m0; i_out1_re = r1; i_out1_im = m1;
    i_valid   = 1'b1;
    if (accept) begin
`ifdef SERIALIZER_HEADER_EN
      exp_q.push_back(8'hA5);
`endif
      push_word(r0); push_word(m0); push_word(r1); push_word(m1);
    end
  endtask

  task automatic send_pulse(input logic [15:0] r0, input logic [15:0] m0,
                            input logic [15:0] r1, input logic [15:0] m1);
    send(r0, m0, r1, m1, 1'b1);
    tick();
    i_valid = 1'b0;
  endtask

  // Called at the negedge of the cycle where a start is due. Plays the UART.
  task automatic serve_frame(input int dly, input int inj_idx, input bit spur,
                             input bit btb, input int abort_idx);
    logic [7:0] exp_b;
    logic [7:0] held;
    int         starts;
    starts = 0;
    for (int b = 0; b < FRAME_LEN; b++) begin
      exp_b = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
      check($sformatf("start_b%0d", b), {31'd0, o_tx_start}, 32'd1);
      check($sformatf("busy_b%0d", b), {31'd0, o_busy}, 32'd1);
      check($sformatf("byte_b%0d", b), {24'd0, o_tx_byte}, {24'd0, exp_b});
      if (o_tx_start) starts++;
      held = o_tx_byte;
      if (b == abort_idx) return;
      if (b == inj_idx) send(16'h1111, 16'h2222, 16'h3333, 16'h4444, 1'b0);
      if (spur) i_tx_done = 1'b1;
      tick();
      i_valid   = 1'b0;
      i_tx_done = 1'b0;
      check("start_one_cycle", {31'd0, o_tx_start}, 32'd0);
      for (int d = 0; d < dly; d++) begin
        tick();
        check("start_held_low", {31'd0, o_tx_start}, 32'd0);
        check("byte_stable", {24'd0, o_tx_byte}, {24'd0, held});
      end
      i_tx_done = 1'b1;
      tick();
      i_tx_done = 1'b0;
    end
    check("start_count", starts, FRAME_LEN);
    check("frame_done", {31'd0, o_frame_done}, 32'd1);
    check("busy_finish", {31'd0, o_busy}, 32'd0);
    check("start_finish", {31'd0, o_tx_start}, 32'd0);
    if (btb) begin
      send(16'hBEEF, 16'h0123, 16'h4567, 16'h89AB, 1'b1);
      tick();
      i_valid = 1'b0;
    end else begin
      tick();
      check("frame_done_once", {31'd0, o_frame_done}, 32'd0);
      check("busy_idle", {31'd0, o_busy}, 32'd0);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; i_valid = 1'b0; i_tx_done = 1'b0;
    i_out0_re = '0; i_out0_im = '0; i_out1_re = '0; i_out1_im = '0;
    tick();
    tick();
    check("rst_start", {31'd0, o_tx_start}, 32'd0);
    check("rst_byte", {24'd0, o_tx_byte}, 32'd0);
    check("rst_busy", {31'd0, o_busy}, 32'd0);
    check("rst_frame_done", {31'd0, o_frame_done}, 32'd0);
    check("rst_overrun", {31'd0, o_overrun}, 32'd0);
    rst = 1'b0;
    tick();

    // Tx_done while idle must not start anything.
    i_tx_done = 1'b1;
    tick();
    i_tx_done = 1'b0;
    tick();
    check("idle_done_ignored", {31'd0, o_tx_start}, 32'd0);

    // Nominal frame, then handshake delays 0, 1 (with spurious done in START), 500.
    send_pulse(16'h0500, 16'h0000, 16'hFF00, 16'h0200);
    serve_frame(10, -1, 1'b0, 1'b0, -1);
    send_pulse(16'hA1B2, 16'hC3D4, 16'hE5F6, 16'h0718);
    serve_frame(0, -1, 1'b0, 1'b0, -1);
    send_pulse(16'h0500, 16'h0000, 16'hFF00, 16'h0200);
    serve_frame(1, -1, 1'b1, 1'b0, -1);
    send_pulse(16'h8001, 16'h7FFE, 16'h00FF, 16'hFF00);
    serve_frame(500, -1, 1'b0, 1'b0, -1);
    check("no_overrun_yet", {31'd0, o_overrun}, 32'd0);

    // Overrun at byte 3: frame unchanged, flag sticky, next valid sends new data.
    send_pulse(16'h0500, 16'h0000, 16'hFF00, 16'h0200);
    serve_frame(3, 3, 1'b0, 1'b0, -1);
    check("overrun_set", {31'd0, o_overrun}, 32'd1);
    repeat (5) tick();
    check("overrun_held", {31'd0, o_overrun}, 32'd1);
    send_pulse(16'h1111, 16'h2222, 16'h3333, 16'h4444);
    serve_frame(2, -1, 1'b0, 1'b0, -1);
    check("overrun_sticky", {31'd0, o_overrun}, 32'd1);

    // Back-to-back: valid in the frame_done cycle starts a new frame, no overrun.
    do_reset();
    check("overrun_cleared", {31'd0, o_overrun}, 32'd0);
    send_pulse(16'h0500, 16'h0000, 16'hFF00, 16'h0200);
    serve_frame(4, -1, 1'b0, 1'b1, -1);
    serve_frame(1, -1, 1'b0, 1'b0, -1);
    check("btb_no_overrun", {31'd0, o_overrun}, 32'd0);

    // Reset mid-frame at byte 5: outputs clear asynchronously, no frame_done.
    send_pulse(16'h0500, 16'h0000, 16'hFF00, 16'h0200);
    serve_frame(2, -1, 1'b0, 1'b0, 5);
    #2 rst = 1'b1;
    #1;
    check("arst_start", {31'd0, o_tx_start}, 32'd0);
    check("arst_byte", {24'd0, o_tx_byte}, 32'd0);
    check("arst_busy", {31'd0, o_busy}, 32'd0);
    check("arst_frame_done", {31'd0, o_frame_done}, 32'd0);
    exp_q.delete();
    tick();
    tick();
    rst = 1'b0;
    for (int c = 0; c < 20; c++) begin
      i_tx_done = (c == 3);
      tick();
      check("post_rst_quiet", {30'd0, o_frame_done, o_tx_start}, 32'd0);
    end
    i_tx_done = 1'b0;
    send_pulse(16'h0500, 16'h0000, 16'hFF00, 16'h0200);
    serve_frame(1, -1, 1'b0, 1'b0, -1);

    check("scoreboard_empty", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/butterfly_result_serializer.md
Name: butterfly_result_serializer

Overview:
Downstream stage of butterfly2. Captures the four WORD_SIZE-bit butterfly results on the butterfly done pulse. Streams them byte by byte into UART_TX using a start/done handshake. Replaces the free-running byte counter and 32-input mux glue with a single self-timed FSM that cannot drop or repeat bytes.

Parameters:
WORD_SIZE, 16, width of each result word; must be a multiple of 8
BYTE_COUNT, 4*WORD_SIZE/8, bytes per frame (derived; do not override)
HEADER_BYTE, 8'hA5, sync byte sent before data when SERIALIZER_HEADER_EN is defined

Ports:
i_clk  in  1  system clock
i_rst  in  1  asynchronous reset, active-high
i_valid  in  1  one-cycle pulse from butterfly2 o_butterfly_done
i_out0_re  in  WORD_SIZE  butterfly output 0, real
i_out0_im  in  WORD_SIZE  butterfly output 0, imaginary
i_out1_re  in  WORD_SIZE  butterfly output 1, real
i_out1_im  in  WORD_SIZE  butterfly output 1, imaginary
i_tx_done  in  1  one-cycle pulse from UART_TX o_TX_done
o_tx_start  out  1  one-cycle start pulse to UART_TX i_start
o_tx_byte  out  8  byte to UART_TX i_TX_byte
o_busy  out  1  high from capture until frame complete
o_frame_done  out  1  one-cycle pulse after last byte's i_tx_done
o_overrun  out  1  sticky; i_valid arrived while busy

Behaviour:
- Reset (async, i_rst=1): state IDLE, byte index 0, capture register 0. All outputs 0: o_tx_start, o_tx_byte, o_busy, o_frame_done, o_overrun.
- States: IDLE, START, WAIT_DONE, FINISH.
- IDLE:
  - i_valid=1 at edge k: latch all four words into the capture register; index←0; go to START; o_busy=1 from cycle k+1.
  - i_tx_done in IDLE is ignored.
- START:
  - o_tx_start=1 for exactly one cycle.
  - o_tx_byte = byte[index], registered. It is valid in the same cycle as o_tx_start and held stable until the next START.
  - Always go to WAIT_DONE.
- WAIT_DONE:
  - Waits indefinitely for i_tx_done=1.
  - On i_tx_done with index<BYTE_COUNT-1: index+1, go to START. The next start pulse occurs the cycle after the done pulse.
  - On i_tx_done with index=BYTE_COUNT-1: go to FINISH.
- FINISH:
  - o_frame_done=1 for one cycle, o_busy=0 in that same cycle.
  - Return to IDLE.
  - i_valid in the FINISH cycle is accepted as a new capture (no lost frame).
- Byte order (little-endian per word, word order fixed): out0_re[7:0], out0_re[15:8], out0_im LSB, out0_im MSB, out1_re LSB, out1_re MSB, out1_im LSB, out1_im MSB. For WORD_SIZE>16, each word emits WORD_SIZE/8 bytes LSB first.
- Latency: i_valid at edge k → first o_tx_start high in cycle k+1.
- Overrun:
  - i_valid while state ≠ IDLE/FINISH: capture register is unchanged and the frame continues untouched.
  - o_overrun←1 and stays 1 until reset.
- Reset mid-frame: immediate return to IDLE and outputs 0. The partial frame is abandoned with no o_frame_done.
- A spurious i_tx_done in START is ignored; only WAIT_DONE consumes it.

Optional Feature:
SERIALIZER_HEADER_EN
- Defined: each frame is prefixed with HEADER_BYTE. Frame length is BYTE_COUNT+1; the header is sent first, then the data bytes as above. o_frame_done follows the last data byte.
- Undefined: no header; frame is exactly BYTE_COUNT bytes. HEADER_BYTE is unused.

Test Plan:
- Nominal frame: butterfly inputs in0=(2,1), in1=(3,-1), tw=(1,0) Q8.8 give out0=(0x0500,0x0000), out1=(0xFF00,0x0200). Pulse i_valid; model UART returns i_tx_done 10 cycles after each start → bytes 00,05,00,00,00,FF,00,02 in order, exactly 8 start pulses, then one o_frame_done, o_busy falls.
- Handshake timing: i_tx_done delayed 0, 1 and 500 cycles after start → each next o_tx_start exactly 1 cycle after i_tx_done, never earlier; o_tx_byte stable between starts.
- Overrun: second i_valid with different data at byte 3 → transmitted bytes still 00,05,00,00,00,FF,00,02; o_overrun=1 and held; a third i_valid after o_frame_done sends the new data.
- Back-to-back: i_valid coincident with the o_frame_done cycle → new frame starts next cycle, no overrun flagged.
- Reset mid-frame: i_rst high at byte 5 → all outputs 0 asynchronously, no o_frame_done; a fresh i_valid after release restarts from byte 0.
- Header (SERIALIZER_HEADER_EN defined): same stimulus as the nominal frame → A5,00,05,00,00,00,FF,00,02; 9 starts.
